instr_encoder: RTL and testbench

//  Inverse of the instruction decode stage: packs MIPS-style field bundles (opcode, rs, rt, rd,

---
 rtl/instr_encoder.sv | 187 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs MIPS-style field bundles into 32-bit instruction words and streams them to instruction memory.
// Optional feature: define ENC_CHECKSUM_EN to add a running XOR checksum output of written words.
module instr_encoder #(
    parameter int J_OPCODE  = 6,
    parameter int MAX_WORDS = 256,
    parameter int CNT_W     = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [5:0]       opcode,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic [4:0]       rd,
    input  logic [4:0]       shamt,
    input  logic [5:0]       funct,
    input  logic [15:0]      immediate,
    input  logic [25:0]      address,
    output logic             imem_we,
    input  logic             imem_ready,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             busy,
    output logic             done,
    output logic             full,
`ifdef ENC_CHECKSUM_EN
    output logic [31:0]      checksum,
`endif
    output logic [CNT_W-1:0] word_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              imem_we_r;
    logic [31:0]       imem_addr_r;
    logic [31:0]       imem_wdata_r;
    logic [31:0]       addr_ptr_r;
    logic [CNT_W-1:0]  word_count_r;
    logic [CNT_W-1:0]  acc_cnt_r;
    logic              busy_r;
    logic              done_r;
    logic              full_r;
    logic              last_taken_r;
    logic              pend_last_r;
`ifdef ENC_CHECKSUM_EN
    logic [31:0]       checksum_r;
`endif

    logic              in_ready_s;
    logic              accept_s;
    logic              wr_done_s;
    logic              start_ok_s;
    logic [CNT_W-1:0]  cnt_next_s;
    logic              hit_max_s;
    logic              end_s;

    // Format selection mirrors the decoder: opcode 0 is R, J_OPCODE is J, everything else I.
    function automatic logic [31:0] pack_word(
        input logic [5:0]  op,
        input logic [4:0]  f_rs,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [4:0]  f_shamt,
        input logic [5:0]  f_funct,
        input logic [15:0] f_imm,
        input logic [25:0] f_addr
    );
        logic [31:0] w;
        if (op == 6'd0) begin
            w = {op, f_rs, f_rt, f_rd, f_shamt, f_funct};
        end else if (op == 6'(J_OPCODE)) begin
            w = {op, f_addr};
        end else begin
            w = {op, f_rs, f_rt, f_imm};
        end
        return w;
    endfunction

    assign in_ready_s = busy_r && (!imem_we_r || imem_ready) && !last_taken_r
                        && (acc_cnt_r < CNT_W'(MAX_WORDS));
    assign accept_s   = in_valid && in_ready_s;
    assign wr_done_s  = imem_we_r && imem_ready;
    assign start_ok_s = start && ((state_r == IDLE) || (state_r == DONE));
    assign cnt_next_s = word_count_r + CNT_W'(1);
    assign hit_max_s  = (cnt_next_s == CNT_W'(MAX_WORDS));
    assign end_s      = wr_done_s && (pend_last_r || hit_max_s);

    // Session state transitions.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = RUN;
                else       state_s = IDLE;
            end
            RUN: begin
                if (end_s) state_s = DONE;
                else       state_s = RUN;
            end
            DONE: begin
                if (start) state_s = RUN;
                else       state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State, one-deep output register, address pointer and session counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= 32'd0;
            imem_wdata_r <= 32'd0;
            addr_ptr_r   <= 32'd0;
            word_count_r <= '0;
            acc_cnt_r    <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            full_r       <= 1'b0;
            last_taken_r <= 1'b0;
            pend_last_r  <= 1'b0;
`ifdef ENC_CHECKSUM_EN
            checksum_r   <= 32'd0;
`endif
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == DONE);
            if (start_ok_s) begin
                addr_ptr_r   <= base_addr & ~32'd3;
                word_count_r <= '0;
                acc_cnt_r    <= '0;
                full_r       <= 1'b0;
                last_taken_r <= 1'b0;
                pend_last_r  <= 1'b0;
`ifdef ENC_CHECKSUM_EN
                checksum_r   <= 32'd0;
`endif
            end else begin
                if (wr_done_s) begin
                    word_count_r <= cnt_next_s;
`ifdef ENC_CHECKSUM_EN
                    checksum_r   <= checksum_r ^ imem_wdata_r;
`endif
                    if (end_s) full_r <= hit_max_s && !pend_last_r;
                end
                // A new accept reloads the register even as the old word completes.
                if (accept_s) begin
                    imem_we_r    <= 1'b1;
                    imem_addr_r  <= addr_ptr_r;
                    imem_wdata_r <= pack_word(opcode, rs, rt, rd, shamt, funct,
                                              immediate, address);
                    addr_ptr_r   <= addr_ptr_r + 32'd4;
                    acc_cnt_r    <= acc_cnt_r + CNT_W'(1);
                    last_taken_r <= in_last;
                    pend_last_r  <= in_last;
                end else if (wr_done_s) begin
                    imem_we_r    <= 1'b0;
                end
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign full       = full_r;
    assign word_count = word_count_r;
`ifdef ENC_CHECKSUM_EN
    assign checksum   = checksum_r;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected writes are queued on accept and compared on imem handshake.
module tb_instr_encoder;

    localparam int MW  = 4;
    localparam int CW  = 3;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_last, imem_ready;
    logic [31:0] base_addr;
    logic        in_ready, imem_we, busy, done, full;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] immediate;
    logic [25:0] address;
    logic [31:0] imem_addr, imem_wdata;
    logic [CW-1:0] word_count;
`ifdef ENC_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_addr;
    int          n_tests = 0;
    int          n_fail  = 0;

    instr_encoder #(.J_OPCODE(6), .MAX_WORDS(MW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .immediate(immediate), .address(address),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done), .full(full),
`ifdef ENC_CHECKSUM_EN
        .checksum(checksum),
`endif
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [5:0] op, input logic [4:0] f_rs,
        input logic [4:0] f_rt, input logic [4:0] f_rd, input logic [4:0] f_sh,
        input logic [5:0] f_fn, input logic [15:0] f_imm, input logic [25:0] f_adr);
        logic [31:0] w;
        w = 32'd0;
        w[31:26] = op;
        if (op == 6'd6) begin
            w[25:0] = f_adr;
        end else begin
            w[25:21] = f_rs;
            w[20:16] = f_rt;
            if (op == 6'd0) begin
                w[15:11] = f_rd;
                w[10:6]  = f_sh;
                w[5:0]   = f_fn;
            end else begin
                w[15:0]  = f_imm;
            end
        end
        return w;
    endfunction

    // Scoreboard monitor: every memory handshake must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && imem_we && imem_ready) begin
            if (sb.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("waddr", imem_addr, e.a);
                check("wdata", imem_wdata, e.d);
            end
        end
    end

    task automatic do_start(input logic [31:0] b);
        base_addr = b;
        start = 1'b1;
        exp_addr = b & ~32'd3;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [5:0] op, input logic [4:0] f_rs, input logic [4:0] f_rt,
        input logic [4:0] f_rd, input logic [4:0] f_sh, input logic [5:0] f_fn,
        input logic [15:0] f_imm, input logic [25:0] f_adr, input logic last,
        input int budget, output logic acc);
        opcode = op; rs = f_rs; rt = f_rt; rd = f_rd; shamt = f_sh; funct = f_fn;
        immediate = f_imm; address = f_adr; in_last = last; in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (acc) begin
            sb.push_back('{exp_addr, model(op, f_rs, f_rt, f_rd, f_sh, f_fn, f_imm, f_adr)});
            exp_addr = exp_addr + 32'd4;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        logic        acc;
        logic [31:0] held_d;
        logic [5:0]  ops[4];
        ops[0] = 6'd0; ops[1] = 6'd6; ops[2] = 6'd8; ops[3] = 6'd35;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; imem_ready = 1'b1;
        base_addr = 32'd0; opcode = 6'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; shamt = 5'd0;
        funct = 6'd0; immediate = 16'd0; address = 26'd0; exp_addr = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_cnt", 32'(word_count), 32'd0);
        check("rst_flags", {28'd0, busy, done, full, in_ready}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // R-format, one-cycle latency
        do_start(32'h0000_0100);
        check("busy", 32'(busy), 32'd1);
        send(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b1, 10, acc);
        check("r_acc", 32'(acc), 32'd1);
        check("r_lat_we", 32'(imem_we), 32'd1);
        check("r_lat_addr", imem_addr, 32'h0000_0100);
        check("r_lat_data", imem_wdata, 32'h0022_1820);
        wait_done("r_done");
        check("r_cnt", 32'(word_count), 32'd1);
        check("r_full", 32'(full), 32'd0);

        // I then J (last), re-armed from DONE
        do_start(32'h0000_0200);
        send(6'd8, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 26'h0, 1'b0, 10, acc);
        check("i_acc", 32'(acc), 32'd1);
        send(6'd6, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0000010, 1'b1, 10, acc);
        check("j_acc", 32'(acc), 32'd1);
        send(6'd8, 5'd4, 5'd4, 5'd0, 5'd0, 6'd0, 16'h1234, 26'h0, 1'b0, 4, acc);
        check("after_last", 32'(acc), 32'd0);
        wait_done("ij_done");
        check("ij_cnt", 32'(word_count), 32'd2);
        check("ij_full", 32'(full), 32'd0);
        check("ij_busy", 32'(busy), 32'd0);
`ifdef ENC_CHECKSUM_EN
        check("ij_csum", checksum, 32'h3822_0015);
`endif

        // Backpressure: three stalled cycles hold the pending write
        do_start(32'h0000_0300);
        imem_ready = 1'b0;
        send(6'd0, 5'd7, 5'd8, 5'd9, 5'd3, 6'h2A, 16'h0, 26'h0, 1'b0, 10, acc);
        held_d = imem_wdata;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_we", 32'(imem_we), 32'd1);
            check("bp_addr", imem_addr, 32'h0000_0300);
            check("bp_data", imem_wdata, held_d);
            check("bp_rdy", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        imem_ready = 1'b1;
        send(6'd35, 5'd1, 5'd31, 5'd0, 5'd0, 6'd0, 16'hFFFC, 26'h0, 1'b1, 10, acc);
        wait_done("bp_done");
        check("bp_cnt", 32'(word_count), 32'd2);

        // MAX_WORDS stop, with address wrap past 0xFFFFFFFC
        do_start(32'hFFFF_FFF9);
        for (int i = 0; i < 6; i++) begin
            send(ops[i % 4], 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 6'($urandom), 16'($urandom), 26'($urandom), 1'b0, (i < MW) ? 10 : 4, acc);
            check("max_acc", 32'(acc), (i < MW) ? 32'd1 : 32'd0);
        end
        wait_done("max_done");
        check("max_full", 32'(full), 32'd1);
        check("max_cnt", 32'(word_count), 32'd4);

        // in_last on word MAX_WORDS is not a full stop
        do_start(32'h0000_1000);
        for (int i = 0; i < MW; i++) begin
            send(6'd8, 5'(i), 5'd1, 5'd0, 5'd0, 6'd0, 16'(i), 26'h0, (i == MW - 1), 10, acc);
        end
        wait_done("ml_done");
        check("ml_full", 32'(full), 32'd0);
        check("ml_cnt", 32'(word_count), 32'd4);

        // Reset with a write pending
        do_start(32'h0000_0400);
        imem_ready = 1'b0;
        send(6'd0, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'h0, 26'h0, 1'b0, 10, acc);
        check("pend_we", 32'(imem_we), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        check("mid_rst_we", 32'(imem_we), 32'd0);
        check("mid_rst_addr", imem_addr, 32'd0);
        check("mid_rst_data", imem_wdata, 32'd0);
        check("mid_rst_flags", {28'd0, busy, done, full, in_ready}, 32'd0);
        check("mid_rst_cnt", 32'(word_count), 32'd0);
        reset = 1'b0;
        imem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("sb_left", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
